// File: rtl/axis_stream_arbiter_if.sv
// AXI-Stream bundle shared by the two requester ports and the forwarded
// output port of axis_stream_arbiter.
interface axis_stream_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    // The producer drives payload and valid, the consumer drives ready.
    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_stream_arbiter.sv
// Two-input packet-locked round-robin AXI-Stream arbiter with a one-stage
// registered output and per-port completed-packet counters.
module axis_stream_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  axis_aclk,
    input  logic                  axis_areset,
    axis_stream_arbiter_if.slave  s00_axis,
    axis_stream_arbiter_if.slave  s01_axis,
    axis_stream_arbiter_if.master m00_axis,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_count0,
    output logic [CNT_WIDTH-1:0]  pkt_count1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_served_q, last_served_d;
    logic [1:0]              grant_q, grant_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [DATA_WIDTH/8-1:0] tstrb_q, tstrb_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [CNT_WIDTH-1:0]    cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]    cnt1_q, cnt1_d;

    logic out_free;
    logic s0_ready, s1_ready;
    logic s0_hs, s1_hs;
    logic s0_last_hs, s1_last_hs;

    // The output register can take a new beat when empty or being drained.
    assign out_free   = ~tvalid_q | m00_axis.tready;
    assign s0_ready   = (state_q == GRANT0) & out_free;
    assign s1_ready   = (state_q == GRANT1) & out_free;
    assign s0_hs      = s0_ready & s00_axis.tvalid;
    assign s1_hs      = s1_ready & s01_axis.tvalid;
    assign s0_last_hs = s0_hs & s00_axis.tlast;
    assign s1_last_hs = s1_hs & s01_axis.tlast;

    assign s00_axis.tready = s0_ready;
    assign s01_axis.tready = s1_ready;

    assign m00_axis.tdata  = tdata_q;
    assign m00_axis.tstrb  = tstrb_q;
    assign m00_axis.tvalid = tvalid_q;
    assign m00_axis.tlast  = tlast_q;
    assign grant           = grant_q;
    assign pkt_count0      = cnt0_q;
    assign pkt_count1      = cnt1_q;

    // Arbitration: pick a requester in IDLE (ties go to the port not served
    // last) and hold it until its tlast beat is accepted.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (s00_axis.tvalid && s01_axis.tvalid) begin
                    state_d = last_served_q ? GRANT0 : GRANT1;
                end else if (s00_axis.tvalid) begin
                    state_d = GRANT0;
                end else if (s01_axis.tvalid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (s0_last_hs) begin
                    state_d       = IDLE;
                    last_served_d = 1'b0;
                end
            end
            GRANT1: begin
                if (s1_last_hs) begin
                    state_d       = IDLE;
                    last_served_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = {state_d == GRANT1, state_d == GRANT0};
    end

    // Output stage: capture any accepted beat, otherwise empty on a drain.
    always_comb begin
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        if (s0_hs) begin
            tdata_d  = s00_axis.tdata;
            tstrb_d  = s00_axis.tstrb;
            tlast_d  = s00_axis.tlast;
            tvalid_d = 1'b1;
        end else if (s1_hs) begin
            tdata_d  = s01_axis.tdata;
            tstrb_d  = s01_axis.tstrb;
            tlast_d  = s01_axis.tlast;
            tvalid_d = 1'b1;
        end else if (m00_axis.tready) begin
            tvalid_d = 1'b0;
        end
    end

    // Packet counters count accepted tlast beats and wrap freely.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (s0_last_hs) cnt0_d = cnt0_q + 1'b1;
        if (s1_last_hs) cnt1_d = cnt1_q + 1'b1;
    end

    // All state registers; reset abandons any partial packet in flight.
    always_ff @(posedge axis_aclk or posedge axis_areset) begin
        if (axis_areset) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            grant_q       <= 2'b00;
            tdata_q       <= '0;
            tstrb_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            cnt0_q        <= '0;
            cnt1_q        <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            grant_q       <= grant_d;
            tdata_q       <= tdata_d;
            tstrb_q       <= tstrb_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            cnt0_q        <= cnt0_d;
            cnt1_q        <= cnt1_d;
        end
    end

endmodule
